// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/reset request per cycle onto a shared SR flag bank.
// Grant, flag update and pulses appear one cycle after the request is sampled; losers stay pending.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDX_W = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*IDX_W-1:0] idx,
  output logic [NREQ-1:0]       gnt,
  output logic [NFLAG-1:0]      q,
  output logic [NFLAG-1:0]      qb,
  output logic [NFLAG-1:0]      s_pulse,
  output logic [NFLAG-1:0]      r_pulse,
  output logic                  conflict,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  hi_elig;
  logic [NREQ-1:0]  win_oh;
  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             win_op;
  logic             win_conflict;
  logic [NFLAG-1:0] flag_oh;

  assign qb = ~q;

  // Requesters at or above ptr take precedence; otherwise wrap to the lowest eligible one.
  always_comb begin
    eligible = req & ~gnt;
    hi_elig  = '0;
    for (int k = 0; k < NREQ; k++) begin
      hi_elig[k] = eligible[k] && (k >= int'(ptr));
    end

    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        win     = PTR_W'(k);
        win_vld = 1'b1;
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hi_elig[k]) begin
        win = PTR_W'(k);
      end
    end

    win_oh = '0;
    if (win_vld) begin
      win_oh[win] = 1'b1;
    end
    win_idx = idx[int'(win)*IDX_W +: IDX_W];
    win_op  = op[win];
    ptr_nxt = (int'(win) == NREQ - 1) ? '0 : PTR_W'(int'(win) + 1);

    win_conflict = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_vld && eligible[k] && (k != int'(win)) &&
          (idx[k*IDX_W +: IDX_W] == win_idx) && (op[k] != win_op)) begin
        win_conflict = 1'b1;
      end
    end

    // Out-of-range indices decode to no flag, so they are granted without effect.
    flag_oh = '0;
    for (int f = 0; f < NFLAG; f++) begin
      flag_oh[f] = win_vld && (int'(win_idx) == f);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      gnt          <= '0;
      q            <= '0;
      s_pulse      <= '0;
      r_pulse      <= '0;
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      gnt      <= win_oh;
      conflict <= win_conflict;
      s_pulse  <= win_op ? flag_oh : '0;
      r_pulse  <= win_op ? '0 : flag_oh;
      q        <= win_op ? (q | flag_oh) : (q & ~flag_oh);
      if (win_vld) begin
        ptr <= ptr_nxt;
      end
      if (win_conflict && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: reference model of the arbitration rules checked every cycle,
// plus directed scenarios with literal expectations; a 6-flag instance covers out-of-range indices.
module tb_sr_flag_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [11:0] idx;

  logic [3:0] gnt, gnt6;
  logic [7:0] q, qb, sp, rp;
  logic [5:0] q6, qb6, sp6, rp6;
  logic       cf, cf6;
  logic [7:0] cnt, cnt6;

  sr_flag_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .q(q), .qb(qb), .s_pulse(sp), .r_pulse(rp),
    .conflict(cf), .conflict_cnt(cnt)
  );

  sr_flag_arbiter #(.NFLAG(6)) dut6 (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx),
    .gnt(gnt6), .q(q6), .qb(qb6), .s_pulse(sp6), .r_pulse(rp6),
    .conflict(cf6), .conflict_cnt(cnt6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit autodrop = 1'b1;

  // Reference model state
  logic [3:0] m_gnt;
  logic [7:0] m_q, m_sp, m_rp;
  logic [5:0] m_q6, m_sp6, m_rp6;
  logic       m_cf;
  int         m_cnt, m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int w;
    int t;
    logic [3:0] el;
    if (rst) begin
      m_gnt = '0; m_q = '0; m_q6 = '0; m_sp = '0; m_rp = '0;
      m_sp6 = '0; m_rp6 = '0; m_cf = 1'b0; m_cnt = 0; m_ptr = 0;
    end else begin
      el = req & ~m_gnt;
      w = -1;
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && el[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
      end
      m_gnt = '0; m_sp = '0; m_rp = '0; m_sp6 = '0; m_rp6 = '0; m_cf = 1'b0;
      if (w >= 0) begin
        t = int'(idx[w*3 +: 3]);
        for (int j = 0; j < 4; j++) begin
          if (j != w && el[j] && int'(idx[j*3 +: 3]) == t && op[j] != op[w]) m_cf = 1'b1;
        end
        if (m_cf) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (t < 8) begin
          m_q[t] = op[w];
          if (op[w]) m_sp[t] = 1'b1; else m_rp[t] = 1'b1;
        end
        if (t < 6) begin
          m_q6[t] = op[w];
          if (op[w]) m_sp6[t] = 1'b1; else m_rp6[t] = 1'b1;
        end
        m_gnt[w] = 1'b1;
        m_ptr = (w + 1) % 4;
      end
    end
  endtask

  // Advance one edge: model samples with the DUT, granted requesters drop req, then stimulus may change.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (autodrop) req = req & ~m_gnt;
    #1;
  endtask

  task automatic rq(input int k, input logic o, input int i);
    req[k] = 1'b1;
    op[k]  = o;
    idx[k*3 +: 3] = 3'(i);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (req != 4'd0 && n < 50) begin
      cyc();
      n++;
    end
    chk("idle_timeout", {28'd0, req}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", {28'd0, gnt}, {28'd0, m_gnt});
      chk("q", {24'd0, q}, {24'd0, m_q});
      chk("qb", {24'd0, qb}, {24'd0, ~m_q});
      chk("s_pulse", {24'd0, sp}, {24'd0, m_sp});
      chk("r_pulse", {24'd0, rp}, {24'd0, m_rp});
      chk("conflict", {31'd0, cf}, {31'd0, m_cf});
      chk("conflict_cnt", {24'd0, cnt}, m_cnt);
      chk("gnt6", {28'd0, gnt6}, {28'd0, m_gnt});
      chk("q6", {26'd0, q6}, {26'd0, m_q6});
      chk("qb6", {26'd0, qb6}, {26'd0, ~m_q6});
      chk("s_pulse6", {26'd0, sp6}, {26'd0, m_sp6});
      chk("r_pulse6", {26'd0, rp6}, {26'd0, m_rp6});
      chk("conflict6", {31'd0, cf6}, {31'd0, m_cf});
      chk("conflict_cnt6", {24'd0, cnt6}, m_cnt);
    end
  end

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0;
    cyc();
    chk_en = 1'b1;

    // Reset wins over simultaneous requests
    rq(0, 1'b1, 0); rq(1, 1'b1, 1); rq(2, 1'b1, 2); rq(3, 1'b1, 3);
    cyc();
    chk("rst_q", {24'd0, q}, 32'h00);
    chk("rst_qb", {24'd0, qb}, 32'hFF);
    chk("rst_gnt", {28'd0, gnt}, 32'h0);
    chk("rst_cnt", {24'd0, cnt}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("first_gnt", {28'd0, gnt}, 32'h1);
    chk("first_q", {24'd0, q}, 32'h01);
    wait_idle();
    cyc();
    chk("all_set_q", {24'd0, q}, 32'h0F);

    // Single set then reset of flag 5
    rq(0, 1'b1, 5);
    cyc();
    chk("set_gnt", {28'd0, gnt}, 32'h1);
    chk("set_q5", {31'd0, q[5]}, 32'h1);
    chk("set_qb5", {31'd0, qb[5]}, 32'h0);
    chk("set_spulse", {24'd0, sp}, 32'h20);
    cyc();
    rq(0, 1'b0, 5);
    cyc();
    chk("rst_q5", {31'd0, q[5]}, 32'h0);
    chk("rst_rpulse", {24'd0, rp}, 32'h20);
    cyc();

    // Redundant reset of an already-clear flag still pulses
    rq(3, 1'b0, 5);
    cyc();
    chk("redund_gnt", {28'd0, gnt}, 32'h8);
    chk("redund_rpulse", {24'd0, rp}, 32'h20);
    cyc();

    // Round-robin with all four holding req continuously
    do_rst();
    autodrop = 1'b0;
    rq(0, 1'b1, 0); rq(1, 1'b1, 1); rq(2, 1'b1, 2); rq(3, 1'b1, 3);
    cyc(); chk("rr_0", {28'd0, gnt}, 32'h1);
    cyc(); chk("rr_1", {28'd0, gnt}, 32'h2);
    cyc(); chk("rr_2", {28'd0, gnt}, 32'h4);
    cyc(); chk("rr_3", {28'd0, gnt}, 32'h8);
    cyc(); chk("rr_4", {28'd0, gnt}, 32'h1);
    req = '0;
    autodrop = 1'b1;
    cyc(); cyc();

    // Opposing requests to flag 2
    do_rst();
    rq(1, 1'b1, 2); rq(2, 1'b0, 2);
    cyc();
    chk("cf_gnt1", {28'd0, gnt}, 32'h2);
    chk("cf_q2_set", {31'd0, q[2]}, 32'h1);
    chk("cf_pulse", {31'd0, cf}, 32'h1);
    chk("cf_cnt1", {24'd0, cnt}, 32'h1);
    cyc();
    chk("cf_gnt2", {28'd0, gnt}, 32'h4);
    chk("cf_q2_clr", {31'd0, q[2]}, 32'h0);
    chk("cf_rpulse", {24'd0, rp}, 32'h04);
    chk("cf_none", {31'd0, cf}, 32'h0);
    cyc();

    // Same-op requests to one flag are not conflicts
    rq(0, 1'b1, 4); rq(1, 1'b1, 4);
    cyc();
    chk("same_op_cf", {31'd0, cf}, 32'h0);
    wait_idle();
    cyc();

    // Drive the counter to saturation
    for (int n = 0; n < 300; n++) begin
      rq(1, 1'b1, 0); rq(2, 1'b0, 0);
      wait_idle();
      cyc();
    end
    chk("sat_cnt", {24'd0, cnt}, 32'hFF);

    // Index 7 is out of range for the 6-flag instance only
    do_rst();
    rq(0, 1'b1, 7);
    cyc();
    chk("oor_gnt6", {28'd0, gnt6}, 32'h1);
    chk("oor_q6", {26'd0, q6}, 32'h0);
    chk("oor_sp6", {26'd0, sp6}, 32'h0);
    chk("oor_rp6", {26'd0, rp6}, 32'h0);
    chk("inr_q", {24'd0, q}, 32'h80);
    chk("inr_sp", {24'd0, sp}, 32'h80);
    cyc();

    // Reset while a grant is pending discards the request
    do_rst();
    rq(0, 1'b1, 3);
    rst = 1'b1;
    cyc();
    chk("mid_q", {24'd0, q}, 32'h0);
    chk("mid_gnt", {28'd0, gnt}, 32'h0);
    rst = 1'b0;
    req = '0;
    cyc();
    chk("mid_q_after", {24'd0, q}, 32'h0);
    chk("mid_gnt_after", {28'd0, gnt}, 32'h0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Round-robin arbiter that shares one bank of SR-style status flags between several requesters.
- Each requester asks to set or reset one flag by index. One request is granted per cycle and applied to the flag bank.
- The block never issues a simultaneous set and reset to the same flag, so the S=R=1 undefined condition cannot occur.
- Sits between control agents and the status-flag storage. Exports the flag values, their complements and a conflict statistic.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAG, 8, number of flags in the bank.
- IDX_W, 3, flag index width; must satisfy 2^IDX_W >= NFLAG.
- CNT_W, 8, width of the conflict counter.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request, level; held until granted.
- op  input  NREQ  per-requester operation: 1 = set flag, 0 = reset flag.
- idx  input  NREQ*IDX_W  per-requester target flag index; requester k uses bits [k*IDX_W +: IDX_W].
- gnt  output  NREQ  one-hot grant, registered, high for exactly one cycle.
- q  output  NFLAG  flag values.
- qb  output  NFLAG  always the bitwise inverse of q, in the same cycle.
- s_pulse  output  NFLAG  one-cycle pulse on the flag that was just set.
- r_pulse  output  NFLAG  one-cycle pulse on the flag that was just reset.
- conflict  output  1  one-cycle pulse when an opposing request lost arbitration.
- conflict_cnt  output  CNT_W  saturating count of conflict events.

Behaviour:
- Reset (rst=1 at an edge):
  - q=0, qb=all ones, gnt=0, s_pulse=0, r_pulse=0, conflict=0, conflict_cnt=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - Reset overrides any request sampled in the same cycle. Reset mid-grant clears gnt on the next cycle, and the request is not applied.
- Eligibility: eligible[k] = req[k] & ~gnt[k].
  - A requester whose gnt is high this cycle is masked.
  - It cannot be granted on back-to-back edges. It must drop req in the cycle gnt is high.
- Arbitration: round-robin search starting at ptr, wrapping modulo NREQ. The winner w is the first eligible requester found.
- At the edge where a winner exists:
  - gnt <= onehot(w).
  - q[idx_w] <= op_w.
  - If op_w=1, s_pulse[idx_w] <= 1; otherwise r_pulse[idx_w] <= 1.
  - ptr <= (w+1) mod NREQ.
- With no eligible requester: gnt, s_pulse and r_pulse are 0 on the next cycle; q and ptr hold.
- Latency: request sampled at edge N. Grant, flag update and pulse are all visible in the cycle after edge N (1 cycle).
- Redundant ops are still granted and pulsed: setting an already-set flag leaves q unchanged.
- Index out of range (idx >= NFLAG): the request is granted but no flag changes and no pulse is issued.
- Conflict: at a grant edge, conflict <= 1 if any other eligible requester targets the same idx with the opposite op.
  - conflict_cnt increments, saturating at 2^CNT_W-1.
  - The losing requester stays pending and is served by later arbitration, so the last-granted op wins.
- Simultaneous same-op requests to the same flag are not conflicts. They are granted in round-robin order on successive cycles.
- Throughput: at most one grant per cycle. A requester holding req continuously is granted every other cycle at best.

Test Plan:
- Reset: assert rst with req=4'b1111 -> next cycle q=0, qb=8'hFF, gnt=0, conflict_cnt=0. After release, the first grant goes to requester 0.
- Single set/reset: req0 with op=1, idx=5 -> one cycle later gnt=4'b0001, q[5]=1, qb[5]=0, s_pulse=8'h20. Then op=0, idx=5 -> q[5]=0, r_pulse=8'h20.
- Round-robin fairness: all four requesters hold req, each on a distinct idx -> grant sequence 0,1,2,3,0. No requester is granted on two consecutive cycles.
- Conflict: req1 sets idx=2 and req2 resets idx=2 in the same cycle, ptr=0.
  - First grant: gnt=4'b0010, q[2]=1, conflict=1, conflict_cnt=1.
  - Next grant: gnt=4'b0100, q[2]=0, r_pulse=8'h04.
- Saturation and out-of-range: force 300 conflicts -> conflict_cnt stays at 255. A request with idx=7 when NFLAG=6 -> gnt pulses, q is unchanged, no s_pulse or r_pulse.
- Reset mid-operation: rst in the cycle a grant is pending -> that request is not applied and q=0.
